// File: rtl/argmax_classifier.sv
// argmax_classifier: sequential signed argmax over a packed activation vector.
// One element is compared per clock; the result index is the predicted class.
module argmax_classifier #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_OF_INPUTS = 10,
  localparam int IDX_W = (NUM_OF_INPUTS > 1) ? $clog2(NUM_OF_INPUTS) : 1
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                IN_VALID,
  input  logic [DATA_WIDTH*NUM_OF_INPUTS-1:0] IN_BITS,
  output logic                                BUSY,
  output logic                                DROPPED,
  output logic [IDX_W-1:0]                    OUT_INDEX,
  output logic [DATA_WIDTH-1:0]               OUT_MAX,
  output logic                                OUT_VALID
);

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_t;

  state_t                             r_state;
  state_t                             w_state_next;
  logic [DATA_WIDTH*NUM_OF_INPUTS-1:0] r_vec;
  logic [DATA_WIDTH-1:0]              r_max;
  logic [IDX_W-1:0]                   r_idx;
  logic [IDX_W-1:0]                   r_cnt;
  logic                               r_busy;
  logic                               r_dropped;
  logic [IDX_W-1:0]                   r_out_idx;
  logic [DATA_WIDTH-1:0]              r_out_max;
  logic                               r_out_valid;

  logic [DATA_WIDTH-1:0]              w_cur;
  logic                               w_gt;
  logic                               w_last;
  logic [DATA_WIDTH-1:0]              w_upd_max;
  logic [IDX_W-1:0]                   w_upd_idx;

  assign BUSY      = r_busy;
  assign DROPPED   = r_dropped;
  assign OUT_INDEX = r_out_idx;
  assign OUT_MAX   = r_out_max;
  assign OUT_VALID = r_out_valid;

  // Select the element addressed by the scan counter from the captured vector.
  always_comb begin
    w_cur = '0;
    for (int unsigned i = 0; i < NUM_OF_INPUTS; i++) begin
      if (r_cnt == IDX_W'(i)) begin
        w_cur = r_vec[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Signed compare against the running max; strict '>' keeps the lowest index on ties.
  always_comb begin
    w_gt      = $signed(w_cur) > $signed(r_max);
    w_upd_max = w_gt ? w_cur : r_max;
    w_upd_idx = w_gt ? r_cnt : r_idx;
    w_last    = (r_cnt == IDX_W'(NUM_OF_INPUTS - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a single-element vector never needs the SCAN state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (IN_VALID && (NUM_OF_INPUTS > 1)) begin
          w_state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: capture, running max/index, counter, result and status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vec       <= '0;
      r_max       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_dropped   <= 1'b0;
      r_out_idx   <= '0;
      r_out_max   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_dropped   <= 1'b0;
      r_busy      <= (w_state_next == S_SCAN);
      case (r_state)
        S_IDLE: begin
          if (IN_VALID) begin
            r_vec <= IN_BITS;
            r_max <= IN_BITS[DATA_WIDTH-1:0];
            r_idx <= '0;
            if (NUM_OF_INPUTS == 1) begin
              r_cnt       <= '0;
              r_out_idx   <= '0;
              r_out_max   <= IN_BITS[DATA_WIDTH-1:0];
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= IDX_W'(1);
            end
          end
        end
        S_SCAN: begin
          r_dropped <= IN_VALID;
          r_max     <= w_upd_max;
          r_idx     <= w_upd_idx;
          if (w_last) begin
            r_cnt       <= '0;
            r_out_idx   <= w_upd_idx;
            r_out_max   <= w_upd_max;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
